// File: rtl/serial_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared definitions for the bit-serial subtractor:
//   - state_t       : two-state sequencer encoding (S_IDLE / S_SHIFT)
//   - DEFAULT_WIDTH : default operand/result width
//   - count_width() : width of the bit counter, clog2(width) with a 1-bit floor
// ---------------------------------------------------------------------------
package serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   function automatic int count_width(input int width);
      return ($clog2(width) < 1) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_subtractor_full_sub_cell.sv
// ---------------------------------------------------------------------------
// full_sub_cell
// Purely combinational 1-bit full subtractor, computing a - b - c.
// Built as two 8:1 multiplexers selected by {a,b,c}; the constant data
// inputs are the truth tables of the two outputs.
// Ports:
//   a  in  1  minuend bit
//   b  in  1  subtrahend bit
//   c  in  1  borrow in
//   d  out 1  difference bit   (minterms 1,2,4,7)
//   bo out 1  borrow out       (minterms 1,2,3,7)
// ---------------------------------------------------------------------------
module full_sub_cell (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic d,
   output logic bo
);

   // Bit i of each table is the mux data input selected when {a,b,c} == i.
   localparam logic [7:0] D_TABLE  = 8'b1001_0110;
   localparam logic [7:0] BO_TABLE = 8'b1000_1110;

   logic [2:0] sel;

   assign sel = {a, b, c};
   assign d   = D_TABLE[sel];
   assign bo  = BO_TABLE[sel];

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit subtractor, diff = a_in - b_in, processed LSB first
// through a single full_sub_cell with the borrow fed back through a register.
// A result takes WIDTH cycles after the accepting edge.
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      synchronous active-high reset (beats start)
//   start      in  1      request, sampled only while idle
//   a_in       in  WIDTH  minuend, captured on an accepted start
//   b_in       in  WIDTH  subtrahend, captured on an accepted start
//   busy       out 1      high while bits are being processed
//   done       out 1      one-cycle pulse, result valid
//   diff       out WIDTH  a_in - b_in mod 2^WIDTH
//   borrow_out out 1      final borrow (a_in < b_in unsigned)
//   overflow   out 1      two's-complement overflow of the subtraction
//
// Handshake: start is a request that is accepted on any rising edge where
// the block is idle (busy=0), including the cycle in which done is high.
// A start while busy is dropped, not queued, and a_in/b_in are not looked
// at again until the next accepted start. done pulses for one cycle when
// diff/borrow_out/overflow are valid; diff shifts partial results while
// busy, so downstream logic should sample it on done.
// ---------------------------------------------------------------------------
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow
);

   localparam int             CW   = count_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t            state_q;
   state_t            state_d;
   logic [WIDTH-1:0]  a_sr;
   logic [WIDTH-1:0]  b_sr;
   logic              brw_q;
   logic [CW-1:0]     count;
   logic              a_msb;
   logic              b_msb;
   logic              cell_d;
   logic              cell_bo;
   logic              last_bit;

   full_sub_cell u_cell (
      .a  (a_sr[0]),
      .b  (b_sr[0]),
      .c  (brw_q),
      .d  (cell_d),
      .bo (cell_bo)
   );

   assign last_bit = (count == LAST);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start)    state_d = S_SHIFT;
         S_SHIFT: if (last_bit) state_d = S_IDLE;
         default:               state_d = S_IDLE;
      endcase
   end

   // Datapath: operand shifters, borrow feedback, counter, result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr       <= '0;
         b_sr       <= '0;
         brw_q      <= 1'b0;
         count      <= '0;
         a_msb      <= 1'b0;
         b_msb      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_sr  <= a_in;
                  b_sr  <= b_in;
                  a_msb <= a_in[WIDTH-1];
                  b_msb <= b_in[WIDTH-1];
                  brw_q <= 1'b0;
                  count <= '0;
                  busy  <= 1'b1;
               end
            end
            S_SHIFT: begin
               diff  <= {cell_d, diff[WIDTH-1:1]};
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               brw_q <= cell_bo;
               count <= count + CW'(1);
               if (last_bit) begin
                  // cell_d here is the result MSB; overflow is only possible
                  // when the operand signs differ and the result sign flips
                  // away from the minuend's sign.
                  borrow_out <= cell_bo;
                  overflow   <= (a_msb != b_msb) & (cell_d != a_msb);
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  count      <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor: one 8-bit instance for directed,
// random, busy-ignore and reset scenarios, one 4-bit instance swept over all
// operand pairs back-to-back. Expected results come from an arithmetic
// reference model and flow through per-instance expected queues.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

   logic       clk;
   logic       rst;

   logic       start8;
   logic [7:0] a8;
   logic [7:0] b8;
   logic       busy8;
   logic       done8;
   logic [7:0] diff8;
   logic       bo8;
   logic       ovf8;

   logic       start4;
   logic [3:0] a4;
   logic [3:0] b4;
   logic       busy4;
   logic       done4;
   logic [3:0] diff4;
   logic       bo4;
   logic       ovf4;

   int check_cnt = 0;
   int pass_cnt  = 0;

   // Expected {overflow, borrow_out, diff}
   logic [9:0] exp_q[$];
   logic [5:0] exp4_q[$];

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk        (clk),
      .rst        (rst),
      .start      (start8),
      .a_in       (a8),
      .b_in       (b8),
      .busy       (busy8),
      .done       (done8),
      .diff       (diff8),
      .borrow_out (bo8),
      .overflow   (ovf8)
   );

   serial_subtractor #(.WIDTH(4)) u_dut4 (
      .clk        (clk),
      .rst        (rst),
      .start      (start4),
      .a_in       (a4),
      .b_in       (b4),
      .busy       (busy4),
      .done       (done4),
      .diff       (diff4),
      .borrow_out (bo4),
      .overflow   (ovf4)
   );

   // ---------------- clock / reset -----------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", pass_cnt, check_cnt);
      $fatal(1);
   end

   // ---------------- reference model ---------------------------------------
   // Returns {overflow, borrow, diff} for a w-bit subtraction a - b.
   function automatic int ref_sub(input int a, input int b, input int w);
      int m, d, brw, sa, sb, r, ov;
      m   = 1 << w;
      d   = (a - b + m) % m;
      brw = (a < b) ? 1 : 0;
      sa  = (a >= m / 2) ? a - m : a;
      sb  = (b >= m / 2) ? b - m : b;
      r   = sa - sb;
      ov  = (r > m / 2 - 1 || r < -(m / 2)) ? 1 : 0;
      return (ov << (w + 1)) | (brw << w) | d;
   endfunction

   // ---------------- driver tasks ------------------------------------------
   // Called on a falling edge: present a start for the next rising edge.
   task automatic drive_start8(input logic [7:0] a, input logic [7:0] b);
      start8 = 1'b1;
      a8     = a;
      b8     = b;
      exp_q.push_back(10'(ref_sub(int'(a), int'(b), 8)));
   endtask

   task automatic drive_start4(input logic [3:0] a, input logic [3:0] b);
      start4 = 1'b1;
      a4     = a;
      b4     = b;
      exp4_q.push_back(6'(ref_sub(int'(a), int'(b), 4)));
   endtask

   // Waits (bounded) for done after an accepted start. lat is the number of
   // cycles from the accepting edge to the edge that raised done, -1 on
   // timeout. Operands are scrambled once start drops.
   task automatic wait_done8(output int lat, output int busy_n);
      lat    = -1;
      busy_n = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start8 = 1'b0;
            a8     = 8'($urandom);
            b8     = 8'($urandom);
         end
         if (busy8) busy_n++;
         if (done8) begin
            lat = k - 1;
            break;
         end
      end
   endtask

   task automatic wait_done4(output int lat);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) start4 = 1'b0;
         if (done4) begin
            lat = k - 1;
            break;
         end
      end
   endtask

   // ---------------- tests --------------------------------------------------
   task automatic test_reset();
      rst    = 1'b1;
      start8 = 1'b0;
      start4 = 1'b0;
      a8 = '0; b8 = '0; a4 = '0; b4 = '0;
      repeat (2) @(negedge clk);
      check_cnt++;
      if ({busy8, done8, diff8, bo8, ovf8} !== 12'h000)
         $display("FAIL reset_8: busy=%b done=%b diff=%h bo=%b ovf=%b, want all 0", busy8, done8, diff8, bo8, ovf8);
      else pass_cnt++;
      check_cnt++;
      if ({busy4, done4, diff4, bo4, ovf4} !== 8'h00)
         $display("FAIL reset_4: busy=%b done=%b diff=%h bo=%b ovf=%b, want all 0", busy4, done4, diff4, bo4, ovf4);
      else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0] ta[4] = '{8'h05, 8'h03, 8'h80, 8'h7F};
      logic [7:0] tb[4] = '{8'h03, 8'h05, 8'h01, 8'hFF};
      logic [7:0] a, b;
      logic [9:0] exp;
      int lat, bn;
      for (int i = 0; i < 24; i++) begin
         if (i < 4) begin
            a = ta[i];
            b = tb[i];
         end else begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
         end
         drive_start8(a, b);
         wait_done8(lat, bn);
         exp = exp_q.pop_front();
         check_cnt++;
         if (lat !== 8)
            $display("FAIL basic_latency a=%h b=%h: got %0d want 8", a, b, lat);
         else pass_cnt++;
         check_cnt++;
         if (bn !== 8)
            $display("FAIL basic_busy_cycles a=%h b=%h: got %0d want 8", a, b, bn);
         else pass_cnt++;
         check_cnt++;
         if ({ovf8, bo8, diff8} !== exp)
            $display("FAIL basic_result a=%h b=%h: got ovf=%b bo=%b diff=%h want ovf=%b bo=%b diff=%h",
                     a, b, ovf8, bo8, diff8, exp[9], exp[8], exp[7:0]);
         else pass_cnt++;
         @(negedge clk);
         check_cnt++;
         if (done8 !== 1'b0 || diff8 !== exp[7:0])
            $display("FAIL basic_hold a=%h b=%h: got done=%b diff=%h want done=0 diff=%h",
                     a, b, done8, diff8, exp[7:0]);
         else pass_cnt++;
      end
   endtask

   task automatic test_busy_ignore();
      logic [9:0] exp;
      int lat, bn;
      lat = -1;
      drive_start8(8'h10, 8'h01);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) start8 = 1'b0;
         if (k == 3) begin
            // Raised while busy and held: must not disturb the running
            // operation, and is taken in the done cycle.
            start8 = 1'b1;
            a8     = 8'hFF;
            b8     = 8'hFF;
         end
         if (done8) begin
            lat = k - 1;
            break;
         end
      end
      exp = exp_q.pop_front();
      check_cnt++;
      if (lat !== 8)
         $display("FAIL ignore_latency: got %0d want 8", lat);
      else pass_cnt++;
      check_cnt++;
      if ({ovf8, bo8, diff8} !== exp)
         $display("FAIL ignore_result: got ovf=%b bo=%b diff=%h want ovf=%b bo=%b diff=%h",
                  ovf8, bo8, diff8, exp[9], exp[8], exp[7:0]);
      else pass_cnt++;
      // start is still high in this done cycle, so it is accepted now.
      exp_q.push_back(10'(ref_sub(int'(8'hFF), int'(8'hFF), 8)));
      wait_done8(lat, bn);
      exp = exp_q.pop_front();
      check_cnt++;
      if (lat !== 8 || bn !== 8)
         $display("FAIL held_start_latency: got lat=%0d busy=%0d want 8/8", lat, bn);
      else pass_cnt++;
      check_cnt++;
      if ({ovf8, bo8, diff8} !== exp)
         $display("FAIL held_start_result: got ovf=%b bo=%b diff=%h want ovf=%b bo=%b diff=%h",
                  ovf8, bo8, diff8, exp[9], exp[8], exp[7:0]);
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [9:0] exp;
      int lat, bn;
      // Leave borrow_out=1 and a nonzero diff behind so the reset is visible.
      drive_start8(8'h03, 8'h05);
      wait_done8(lat, bn);
      exp = exp_q.pop_front();
      check_cnt++;
      if ({ovf8, bo8, diff8} !== exp)
         $display("FAIL pre_reset_result: got ovf=%b bo=%b diff=%h want %h", ovf8, bo8, diff8, exp);
      else pass_cnt++;
      @(negedge clk);
      drive_start8(8'hA5, 8'h3C);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) start8 = 1'b0;
      end
      rst = 1'b1;
      void'(exp_q.pop_back());
      @(negedge clk);
      check_cnt++;
      if ({busy8, done8, diff8, bo8, ovf8} !== 12'h000)
         $display("FAIL mid_reset: busy=%b done=%b diff=%h bo=%b ovf=%b, want all 0", busy8, done8, diff8, bo8, ovf8);
      else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
      drive_start8(8'h37, 8'h12);
      wait_done8(lat, bn);
      exp = exp_q.pop_front();
      check_cnt++;
      if (lat !== 8 || {ovf8, bo8, diff8} !== exp)
         $display("FAIL post_reset_op: got lat=%0d ovf=%b bo=%b diff=%h want lat=8 result=%h",
                  lat, ovf8, bo8, diff8, exp);
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_exhaustive4();
      logic [5:0] exp;
      int lat;
      @(negedge clk);
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            // Issued on the done negedge of the previous pair: back-to-back.
            drive_start4(4'(a), 4'(b));
            wait_done4(lat);
            exp = exp4_q.pop_front();
            check_cnt++;
            if (lat !== 4)
               $display("FAIL w4_latency a=%h b=%h: got %0d want 4", a, b, lat);
            else pass_cnt++;
            check_cnt++;
            if ({ovf4, bo4, diff4} !== exp)
               $display("FAIL w4_result a=%h b=%h: got ovf=%b bo=%b diff=%h want ovf=%b bo=%b diff=%h",
                        a, b, ovf4, bo4, diff4, exp[5], exp[4], exp[3:0]);
            else pass_cnt++;
         end
      end
      @(negedge clk);
   endtask

   // ---------------- sequence + report -------------------------------------
   initial begin
      test_reset();
      test_basic();
      test_busy_ignore();
      test_reset_mid();
      test_exhaustive4();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
